// File: rtl/la_capture_controller.sv
// Logic-analyzer capture controller: drives a circular sample-memory write port with pre-trigger
// fill, three trigger modes and a six-register window on the daisy-chained register bus.
module la_capture_controller #(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned SAMPLE_DEPTH = 1024,
  parameter int unsigned ADDR_W       = $clog2(SAMPLE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [15:0]       addr_i,
  input  logic [15:0]       wdata_i,
  input  logic [15:0]       rdata_i,
  input  logic              rw_i,
  input  logic              valid_i,
  output logic [15:0]       addr_o,
  output logic [15:0]       wdata_o,
  output logic [15:0]       rdata_o,
  output logic              rw_o,
  output logic              valid_o
);

  typedef enum logic [2:0] {
    StIdle           = 3'd0,
    StMoveToPosition = 3'd1,
    StInPosition     = 3'd2,
    StCapturing      = 3'd3,
    StCaptured       = 3'd4
  } state_e;

  localparam logic [1:0] ModeImmediate   = 2'd1;
  localparam logic [1:0] ModeIncremental = 2'd2;
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(SAMPLE_DEPTH - 1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] trig_loc_q, tl_q, tl_d;
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d, rem_q, rem_d;

  logic [15:0]       offset, reg_rdata;
  logic              hit, wr_hit, rd_hit, start, stop, we, incr, imm;
  logic [ADDR_W-1:0] tl_eff, tl_wr;

  // Offsets below BASE_ADDR wrap to large values and therefore miss.
  always_comb begin
    offset = addr_i - 16'(BASE_ADDR);
    hit    = valid_i && (offset < 16'd6);
    wr_hit = hit && rw_i;
    rd_hit = hit && !rw_i;
    start  = wr_hit && (offset == 16'd1) && (wdata_i == 16'd1);
    stop   = wr_hit && (offset == 16'd1) && (wdata_i == 16'd2);
    tl_wr  = ({16'd0, wdata_i} >= 32'(SAMPLE_DEPTH)) ? LastIdx : wdata_i[ADDR_W-1:0];
    incr   = (mode_q == ModeIncremental);
    imm    = (mode_q == ModeImmediate);
    tl_eff = incr ? '0 : trig_loc_q;
  end

  always_comb begin
    reg_rdata = '0;
    case (offset)
      16'd0:   reg_rdata = 16'(state_q);
      16'd2:   reg_rdata = 16'(mode_q);
      16'd3:   reg_rdata = 16'(trig_loc_q);
      16'd4:   reg_rdata = 16'(wp_q);
      16'd5:   reg_rdata = 16'(rp_q);
      default: reg_rdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    tl_d    = tl_q;
    we      = 1'b0;
    case (state_q)
      StIdle: ;
      StMoveToPosition: begin
        we    = 1'b1;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == tl_q - ADDR_W'(1)) state_d = StInPosition;
      end
      StInPosition: begin
        we = incr ? trig : 1'b1;
        if (trig || imm) begin
          if (rem_q == '0) begin
            state_d = StCaptured;
            rp_d    = wp_q + ADDR_W'(1);
          end else begin
            state_d = StCapturing;
          end
        end
      end
      StCapturing: begin
        we = incr ? trig : 1'b1;
        if (we) begin
          rem_d = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = StCaptured;
            rp_d    = wp_q + ADDR_W'(1);
          end
        end
      end
      StCaptured: ;
      default: state_d = StIdle;
    endcase
    if (we) wp_d = wp_q + ADDR_W'(1);
    // A start overrides whatever the capture was doing, including completion.
    if (start) begin
      wp_d    = '0;
      cnt_d   = '0;
      tl_d    = tl_eff;
      rem_d   = LastIdx - tl_eff;
      state_d = (tl_eff != '0) ? StMoveToPosition : StInPosition;
    end else if (stop) begin
      state_d = StIdle;
    end
  end

  assign bram_we_o   = we;
  assign bram_addr_o = wp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      trig_loc_q <= '0;
      tl_q       <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
    end else begin
      state_q <= state_d;
      tl_q    <= tl_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      if (wr_hit && offset == 16'd2) mode_q <= wdata_i[1:0];
      if (wr_hit && offset == 16'd3) trig_loc_q <= tl_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_o  <= '0;
      wdata_o <= '0;
      rdata_o <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      addr_o  <= addr_i;
      wdata_o <= wdata_i;
      rdata_o <= rd_hit ? reg_rdata : rdata_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
    end
  end

endmodule
